dds_cmd_sequencer: RTL

//  Command sequencer between spi_slave_4byte and the DDS core. Takes each 32-bit SPI word
//  {byte2,byte1,byte0,opcode}, decodes it, loads shadow DDS registers and commits them

---
 rtl/dds_cmd_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dds_cmd_sequencer.sv
// Command sequencer between spi_slave_4byte and the DDS core: decodes SPI words into
// shadow registers, commits them atomically, and queues 24-bit replies to the slave.
module dds_cmd_sequencer #(
    parameter logic [31:0] FTW_RESET     = 32'h0000_0000,
    parameter int unsigned AMP_W         = 12,
    parameter int unsigned REPLY_TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_data_available,
    input  logic [31:0]      rd_data,
    output logic             rd_ack,
    input  logic             wr_buffer_free,
    output logic             wr_en,
    output logic [23:0]      wr_data,
    output logic [31:0]      ftw,
    output logic [15:0]      phase,
    output logic [AMP_W-1:0] amp,
    output logic [1:0]       wave_sel,
    output logic             dds_update,
    output logic             busy,
    output logic [7:0]       err_count
);

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_INIT   = 8'h01;
    localparam logic [7:0] OP_FTW_LO = 8'h10;
    localparam logic [7:0] OP_FTW_HI = 8'h11;
    localparam logic [7:0] OP_PHASE  = 8'h12;
    localparam logic [7:0] OP_AMP    = 8'h13;
    localparam logic [7:0] OP_WAVE   = 8'h14;
    localparam logic [7:0] OP_COMMIT = 8'h20;
    localparam logic [7:0] OP_READ   = 8'h30;
    localparam logic [7:0] OP_STATUS = 8'h31;

    localparam int unsigned TMO_W = $clog2(REPLY_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(REPLY_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, REPLY, WAIT_CLR} state_t;

    state_t           state, state_nxt;
    logic [31:0]      cmd;
    logic [7:0]       opcode;
    logic [23:0]      payload;
    logic [31:0]      sh_ftw;
    logic [15:0]      sh_phase;
    logic [AMP_W-1:0] sh_amp;
    logic [1:0]       sh_wave;
    logic             pending;
    logic [7:0]       cmd_count;
    logic [23:0]      reply;
    logic [23:0]      read_val;
    logic [23:0]      status_val;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             is_reply_op;

    assign opcode      = cmd[7:0];
    assign payload     = cmd[31:8];
    assign is_reply_op = (opcode == OP_READ) || (opcode == OP_STATUS);
    assign tmo_hit     = !wr_buffer_free && (tmo_cnt == TMO_LAST);

    // Status reports the count including the STATUS word being executed.
    assign status_val = {err_count, cmd_count + 8'd1, 7'h0, pending};

    always_comb begin
        read_val = 24'hEEEEEE;
        case (payload[2:0])
            3'd0:    read_val = ftw[23:0];
            3'd1:    read_val = {16'h0, ftw[31:24]};
            3'd2:    read_val = {8'h0, phase};
            3'd3:    read_val = 24'(amp);
            3'd4:    read_val = {22'h0, wave_sel};
            default: read_val = 24'hEEEEEE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (rd_data_available) state_nxt = EXEC;
            EXEC:     state_nxt = is_reply_op ? REPLY : WAIT_CLR;
            REPLY:    if (wr_buffer_free || tmo_hit) state_nxt = WAIT_CLR;
            WAIT_CLR: if (!rd_data_available) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_ack = (state == EXEC);
        busy   = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cmd        <= '0;
            sh_ftw     <= FTW_RESET;
            sh_phase   <= '0;
            sh_amp     <= '0;
            sh_wave    <= '0;
            ftw        <= FTW_RESET;
            phase      <= '0;
            amp        <= '0;
            wave_sel   <= '0;
            pending    <= 1'b0;
            cmd_count  <= '0;
            err_count  <= '0;
            reply      <= '0;
            tmo_cnt    <= '0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            dds_update <= 1'b0;
        end else begin
            dds_update <= 1'b0;
            wr_en      <= 1'b0;
            if (state == IDLE && rd_data_available) begin
                cmd <= rd_data;
            end
            if (state == EXEC) begin
                cmd_count <= cmd_count + 8'd1;
                tmo_cnt   <= '0;
                reply     <= (opcode == OP_READ) ? read_val : status_val;
                case (opcode)
                    OP_FTW_LO: begin sh_ftw[23:0]  <= payload;          pending <= 1'b1; end
                    OP_FTW_HI: begin sh_ftw[31:24] <= payload[7:0];     pending <= 1'b1; end
                    OP_PHASE:  begin sh_phase      <= payload[15:0];    pending <= 1'b1; end
                    OP_AMP:    begin sh_amp        <= payload[AMP_W-1:0]; pending <= 1'b1; end
                    OP_WAVE:   begin sh_wave       <= payload[1:0];     pending <= 1'b1; end
                    OP_COMMIT: begin
                        ftw        <= sh_ftw;
                        phase      <= sh_phase;
                        amp        <= sh_amp;
                        wave_sel   <= sh_wave;
                        dds_update <= 1'b1;
                        pending    <= 1'b0;
                    end
                    OP_READ, OP_STATUS, OP_NOP, OP_INIT: ;
                    default: if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                endcase
            end
            if (state == REPLY) begin
                if (wr_buffer_free) begin
                    wr_en   <= 1'b1;
                    wr_data <= reply;
                end else if (tmo_hit) begin
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule
